// File: rtl/pmp_unit_pkg.sv
// ============================================================================
//  Module      : cep_define (package)
//  Description : Shared PMP types, encodings and CSR addresses for the CEP core.
//                Optional feature macro: PMP_NAPOT_EN (NA4/NAPOT decoding).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cep_define;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [1:0] c_oper_r = 2'b00;
    localparam logic [1:0] c_oper_w = 2'b01;
    localparam logic [1:0] c_oper_x = 2'b10;

    localparam logic [1:0] c_priv_u = 2'b00;
    localparam logic [1:0] c_priv_s = 2'b01;
    localparam logic [1:0] c_priv_m = 2'b11;

    localparam logic [11:0] c_csr_pmpcfg0  = 12'h3A0;
    localparam logic [11:0] c_csr_pmpaddr0 = 12'h3B0;

    // Legalises a written config byte: reserved bits zero, no W without R.
    function automatic pmpcfg_t warl_cfg(input logic [7:0] b);
        pmpcfg_t c;
        c.l    = b[7];
        c.rsvd = 2'b00;
        c.a    = pmp_a_e'(b[4:3]);
`ifndef PMP_NAPOT_EN
        if (b[4]) c.a = A_OFF;
`endif
        c.x    = b[2];
        c.w    = b[1] & b[0];
        c.r    = b[0];
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pmp_addr_match.sv
// ============================================================================
//  Module      : pmp_addr_match
//  Description : Range comparison of one PMP entry against an access span.
//                NA4/NAPOT decoding is built only with PMP_NAPOT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_addr_match
    import cep_define::*;
(
    input  logic [35:0] req_lo,
    input  logic [35:0] req_hi,
    input  pmp_a_e      a,
    input  logic [31:0] addr_prev,
    input  logic [31:0] addr_cur,
    output logic        any_match,
    output logic        full_match
);

    logic [35:0] w_base;
    logic [35:0] w_top;
    logic        w_en;

`ifdef PMP_NAPOT_EN
    // Low bits set through the lowest zero of pmpaddr: 2^(k+1)-1 in word units.
    logic [32:0] w_mask;
    assign w_mask = {1'b0, addr_cur} ^ ({1'b0, addr_cur} + 33'd1);
`endif

    always_comb begin
        w_en   = 1'b0;
        w_base = '0;
        w_top  = '0;
        case (a)
            A_TOR: begin
                w_base = {2'b00, addr_prev, 2'b00};
                w_top  = {2'b00, addr_cur, 2'b00};
                w_en   = (w_base < w_top);
            end
`ifdef PMP_NAPOT_EN
            A_NA4: begin
                w_base = {4'b0000, addr_cur[29:0], 2'b00};
                w_top  = w_base + 36'd4;
                w_en   = 1'b1;
            end
            A_NAPOT: begin
                w_base = {2'b00, addr_cur & ~w_mask[31:0], 2'b00};
                w_top  = w_base + {1'b0, w_mask + 33'd1, 2'b00};
                w_en   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign any_match  = w_en && (req_lo < w_top) && (req_hi >= w_base);
    assign full_match = w_en && (req_lo >= w_base) && (req_hi < w_top);

endmodule

`default_nettype wire

// File: rtl/pmp_unit.sv
// ============================================================================
//  Module      : pmp_unit
//  Description : Registered PMP checker with CSR-mapped, lockable entries and
//                first-fault capture. Optional macro: PMP_NAPOT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_unit
    import cep_define::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_oper,
    input  logic [1:0]  req_priv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_fault,
    output logic [4:0]  rsp_entry,
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    input  logic        fault_clr
);

    pmpcfg_t     r_cfg  [NUM_ENTRIES];
    logic [31:0] r_addr [NUM_ENTRIES];
    logic [31:0] w_prev [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_cfg_we;
    logic [NUM_ENTRIES-1:0] w_addr_we;
    logic [NUM_ENTRIES-1:0] w_tor_lock;
    logic [NUM_ENTRIES-1:0] w_any;
    logic [NUM_ENTRIES-1:0] w_full;

    logic [35:0] w_lo;
    logic [35:0] w_hi;
    logic        w_hit;
    logic [4:0]  w_sel;
    logic        w_sel_full;
    pmpcfg_t     w_sel_cfg;
    logic        w_perm;
    logic        w_fault;
    logic        w_accept;

    // pmpaddr[i] is frozen when the entry above uses it as a locked TOR base.
    always_comb begin
        w_tor_lock = '0;
        w_prev[0]  = '0;
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            w_tor_lock[i-1] = r_cfg[i].l && (r_cfg[i].a == A_TOR);
            w_prev[i]       = r_addr[i-1];
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_cfg_we[i]  = csr_we && (csr_addr == c_csr_pmpcfg0 + 12'(i / 4)) && !r_cfg[i].l;
            w_addr_we[i] = csr_we && (csr_addr == c_csr_pmpaddr0 + 12'(i))
                           && !r_cfg[i].l && !w_tor_lock[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_cfg_we[i])  r_cfg[i]  <= warl_cfg(csr_wdata[8*(i%4) +: 8]);
                if (w_addr_we[i]) r_addr[i] <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int g = 0; g < NUM_ENTRIES / 4; g++) begin
            if (csr_addr == c_csr_pmpcfg0 + 12'(g))
                csr_rdata = {r_cfg[4*g+3], r_cfg[4*g+2], r_cfg[4*g+1], r_cfg[4*g]};
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (csr_addr == c_csr_pmpaddr0 + 12'(i))
                csr_rdata = r_addr[i];
        end
    end

    // 36-bit span so the last byte of an access near 4 GiB cannot wrap.
    assign w_lo = {4'b0000, req_addr};
    assign w_hi = w_lo + (36'd1 << req_size) - 36'd1;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_match
        pmp_addr_match u_match (
            .req_lo     (w_lo),
            .req_hi     (w_hi),
            .a          (r_cfg[i].a),
            .addr_prev  (w_prev[i]),
            .addr_cur   (r_addr[i]),
            .any_match  (w_any[i]),
            .full_match (w_full[i])
        );
    end

    always_comb begin
        w_hit      = 1'b0;
        w_sel      = 5'(NUM_ENTRIES);
        w_sel_full = 1'b0;
        w_sel_cfg  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_any[i]) begin
                w_hit      = 1'b1;
                w_sel      = 5'(i);
                w_sel_full = w_full[i];
                w_sel_cfg  = r_cfg[i];
            end
        end
    end

    always_comb begin
        case (req_oper)
            c_oper_r: w_perm = w_sel_cfg.r;
            c_oper_w: w_perm = w_sel_cfg.w;
            c_oper_x: w_perm = w_sel_cfg.x;
            default:  w_perm = 1'b0;
        endcase
        if (req_size == 2'b11 || req_oper == 2'b11)
            w_fault = 1'b1;
        else if (w_hit && !w_sel_full)
            w_fault = 1'b1;
        else if (w_hit)
            w_fault = (req_priv == c_priv_m) ? (w_sel_cfg.l && !w_perm) : !w_perm;
        else
            w_fault = (req_priv != c_priv_m);
    end

    assign req_ready = !rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_fault   <= 1'b0;
            rsp_entry   <= '0;
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else begin
            if (w_accept) begin
                rsp_valid <= 1'b1;
                rsp_fault <= w_fault;
                rsp_entry <= w_sel;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (w_accept && w_fault && (!fault_valid || fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr  <= req_addr;
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
